mem_arbiter: RTL and testbench

- Shares one single-port memory bus between the instruction fetch requester and the data requester (driven by the control unit's dread/dwrite).
- Sequences each access with a three-state FSM and gives data priority, with a streak limit so fetch is never starved.
- Generates byte strobes and lane-aligned store data from dwrite and the low address bits.
- Flags misaligned data accesses instead of issuing them.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter_store_align.sv | 37 +++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  localparam logic [1:0] DW_NONE = 2'd0;
  localparam logic [1:0] DW_BYTE = 2'd1;
  localparam logic [1:0] DW_HALF = 2'd2;
  localparam logic [1:0] DW_WORD = 2'd3;

  typedef logic [3:0] strobe_t;

  localparam strobe_t STROBE_ALL = 4'hF;

  // Clear the byte offset so the memory only ever sees word addresses.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// slave: the arbiter's view. master: the environment (requesters + memory).
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        iren;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dren;
  logic [1:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        dfault;

  logic        ram_ren;
  logic        ram_wen;
  strobe_t     ram_strobe;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;

  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    output iwait, iload, dwait, dload, dfault,
           ram_ren, ram_wen, ram_strobe, ram_addr, ram_store
  );

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
    input  iwait, iload, dwait, dload, dfault,
           ram_ren, ram_wen, ram_strobe, ram_addr, ram_store
  );

endinterface

// File: rtl/mem_arbiter_store_align.sv
// Store lane alignment: byte enables, replicated store data and misalignment flag.
module store_align
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  dwen_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] dstore_i,
  output strobe_t     strobe_o,
  output logic [31:0] store_o,
  output logic        misalign_o
);

  // Replicate the right-justified data so every candidate lane carries it.
  always_comb begin
    strobe_o   = '0;
    store_o    = '0;
    misalign_o = 1'b0;
    case (dwen_i)
      DW_BYTE: begin
        strobe_o = strobe_t'(4'b0001 << addr_lo_i);
        store_o  = {4{dstore_i[7:0]}};
      end
      DW_HALF: begin
        strobe_o   = strobe_t'(4'b0011 << addr_lo_i);
        store_o    = {2{dstore_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      DW_WORD: begin
        strobe_o   = STROBE_ALL;
        store_o    = dstore_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has priority; a streak counter forces a fetch after DATA_STREAK
// consecutive data grants made while fetch was waiting.
//
//   state | meaning
//   IDLE  | arbitration cycle, no bus access, faulty data requests flagged
//   IBUSY | fetch owns the bus until ram_ready
//   DBUSY | data read/write owns the bus until ram_ready
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_STREAK = 4
) (
  input  logic           clk,
  input  logic           nrst,
  mem_arbiter_if.slave   bus
);

  localparam logic [3:0] STREAK_MAX = DATA_STREAK[3:0];

  arb_state_t  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  strobe_t     strobe_q, strobe_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;

  strobe_t     sa_strobe;
  logic [31:0] sa_store;
  logic        sa_misalign;

  logic        d_valid;
  logic        d_fault;

  logic        iwait, dwait, dfault;
  logic [31:0] iload, dload;
  logic        ram_ren, ram_wen;
  strobe_t     ram_strobe;
  logic [31:0] ram_addr, ram_store;

  store_align u_store_align (
    .dwen_i     (bus.dwen),
    .addr_lo_i  (bus.daddr[1:0]),
    .dstore_i   (bus.dstore),
    .strobe_o   (sa_strobe),
    .store_o    (sa_store),
    .misalign_o (sa_misalign)
  );

  assign d_valid = bus.dren | (bus.dwen != DW_NONE);
  assign d_fault = (bus.dren & (bus.dwen != DW_NONE)) | sa_misalign;

  // Next-state, request latching, streak update and all bus/requester outputs.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    strobe_d   = strobe_q;
    store_d    = store_q;
    wr_d       = wr_q;
    iwait      = bus.iren;
    dwait      = d_valid;
    dfault     = 1'b0;
    iload      = '0;
    dload      = '0;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_strobe = '0;
    ram_addr   = '0;
    ram_store  = '0;

    case (state_q)
      IDLE: begin
        dfault = nrst & d_fault;
        dwait  = d_valid & ~dfault;
        if (!bus.iren) streak_d = '0;
        if (dfault) begin
          // A rejected data request also blocks fetch for this cycle.
        end else if (bus.iren && streak_q == STREAK_MAX) begin
          state_d  = IBUSY;
          streak_d = '0;
          addr_d   = word_addr(bus.iaddr);
          strobe_d = STROBE_ALL;
          store_d  = '0;
          wr_d     = 1'b0;
        end else if (d_valid) begin
          state_d  = DBUSY;
          if (bus.iren && streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
          addr_d   = word_addr(bus.daddr);
          strobe_d = bus.dren ? STROBE_ALL : sa_strobe;
          store_d  = bus.dren ? 32'h0 : sa_store;
          wr_d     = ~bus.dren;
        end else if (bus.iren) begin
          state_d  = IBUSY;
          streak_d = '0;
          addr_d   = word_addr(bus.iaddr);
          strobe_d = STROBE_ALL;
          store_d  = '0;
          wr_d     = 1'b0;
        end
      end

      IBUSY: begin
        ram_ren    = 1'b1;
        ram_strobe = strobe_q;
        ram_addr   = addr_q;
        iwait      = ~bus.ram_ready;
        if (bus.ram_ready) begin
          iload   = bus.ram_load;
          state_d = IDLE;
        end
      end

      DBUSY: begin
        ram_ren    = ~wr_q;
        ram_wen    = wr_q;
        ram_strobe = strobe_q;
        ram_addr   = addr_q;
        ram_store  = store_q;
        dwait      = ~bus.ram_ready;
        if (bus.ram_ready) begin
          dload   = bus.ram_load;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and latched request; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      strobe_q <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.iwait      = iwait;
  assign bus.iload      = iload;
  assign bus.dwait      = dwait;
  assign bus.dload      = dload;
  assign bus.dfault     = dfault;
  assign bus.ram_ren    = ram_ren;
  assign bus.ram_wen    = ram_wen;
  assign bus.ram_strobe = ram_strobe;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_store  = ram_store;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle vectors for mem_arbiter plus starvation and reset sequences.
module tb_mem_arbiter;

  typedef struct {
    logic        nrst;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic [1:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rload;
    logic        rrdy;
    logic        e_iwait;
    logic [31:0] e_iload;
    logic        e_dwait;
    logic [31:0] e_dload;
    logic        e_dfault;
    logic        e_ren;
    logic        e_wen;
    logic [3:0]  e_strobe;
    logic [31:0] e_addr;
    logic [31:0] e_store;
  } vec_t;

  logic clk;
  logic nrst;
  int   n_vec;
  int   n_miss;

  mem_arbiter_if bus ();

  mem_arbiter #(.DATA_STREAK(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [1:0] dw, input logic [31:0] da, input logic [31:0] ds,
                       input logic [31:0] rl, input logic rr);
    nrst          = r;
    bus.iren      = ir;
    bus.iaddr     = ia;
    bus.dren      = dr;
    bus.dwen      = dw;
    bus.daddr     = da;
    bus.dstore    = ds;
    bus.ram_load  = rl;
    bus.ram_ready = rr;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.nrst, v.iren, v.iaddr, v.dren, v.dwen, v.daddr, v.dstore, v.rload, v.rrdy);
    #1;
    n_vec++;
    chk("iwait",      idx, {31'd0, bus.iwait},      {31'd0, v.e_iwait});
    chk("iload",      idx, bus.iload,               v.e_iload);
    chk("dwait",      idx, {31'd0, bus.dwait},      {31'd0, v.e_dwait});
    chk("dload",      idx, bus.dload,               v.e_dload);
    chk("dfault",     idx, {31'd0, bus.dfault},     {31'd0, v.e_dfault});
    chk("ram_ren",    idx, {31'd0, bus.ram_ren},    {31'd0, v.e_ren});
    chk("ram_wen",    idx, {31'd0, bus.ram_wen},    {31'd0, v.e_wen});
    chk("ram_strobe", idx, {28'd0, bus.ram_strobe}, {28'd0, v.e_strobe});
    chk("ram_addr",   idx, bus.ram_addr,            v.e_addr);
    chk("ram_store",  idx, bus.ram_store,           v.e_store);
  endtask

  vec_t tbl [26];
  vec_t rs  [10];
  logic exp_own [6];
  int   grants;
  logic own;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);

    //          nrst iren iaddr     dren dwen  daddr      dstore        rload         rrdy  iwait iload         dwait dload         dflt ren  wen  strobe addr       store
    tbl[0]  = '{1'b0,1'b0,32'h0,    1'b0,2'd0,32'h0,     32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[1]  = '{1'b0,1'b1,32'h100,  1'b1,2'd0,32'h0,     32'h0,        32'h0,        1'b0, 1'b1,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[2]  = '{1'b1,1'b1,32'h100,  1'b0,2'd0,32'h0,     32'h0,        32'h11112222, 1'b1, 1'b1,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[3]  = '{1'b1,1'b1,32'h104,  1'b0,2'd0,32'h0,     32'h0,        32'hDEADBEEF, 1'b1, 1'b0,32'hDEADBEEF, 1'b0,32'h0,        1'b0,1'b1,1'b0,4'hF,32'h100,  32'h0};
    tbl[4]  = '{1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[5]  = '{1'b1,1'b1,32'h200,  1'b1,2'd0,32'h300,   32'h0,        32'h0,        1'b0, 1'b1,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[6]  = '{1'b1,1'b1,32'h200,  1'b1,2'd0,32'h300,   32'h0,        32'h55,       1'b0, 1'b1,32'h0,        1'b1,32'h0,        1'b0,1'b1,1'b0,4'hF,32'h300,  32'h0};
    tbl[7]  = '{1'b1,1'b1,32'h200,  1'b1,2'd0,32'h300,   32'h0,        32'hCAFEF00D, 1'b1, 1'b1,32'h0,        1'b0,32'hCAFEF00D, 1'b0,1'b1,1'b0,4'hF,32'h300,  32'h0};
    tbl[8]  = '{1'b1,1'b1,32'h200,  1'b0,2'd0,32'h0,     32'h0,        32'h0,        1'b0, 1'b1,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[9]  = '{1'b1,1'b1,32'h200,  1'b0,2'd0,32'h0,     32'h0,        32'h600D,     1'b1, 1'b0,32'h600D,     1'b0,32'h0,        1'b0,1'b1,1'b0,4'hF,32'h200,  32'h0};
    tbl[10] = '{1'b1,1'b0,32'h0,    1'b0,2'd1,32'h203,   32'h123456AB, 32'h0,        1'b1, 1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[11] = '{1'b1,1'b0,32'h0,    1'b0,2'd1,32'h203,   32'h123456AB, 32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b1,4'h8,32'h200,  32'hABABABAB};
    tbl[12] = '{1'b1,1'b0,32'h0,    1'b0,2'd1,32'h0,     32'hFFFFFFFF, 32'h77,       1'b1, 1'b0,32'h0,        1'b0,32'h77,       1'b0,1'b0,1'b1,4'h8,32'h200,  32'hABABABAB};
    tbl[13] = '{1'b1,1'b0,32'h0,    1'b0,2'd2,32'h202,   32'h0000BEEF, 32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[14] = '{1'b1,1'b0,32'h0,    1'b0,2'd2,32'h202,   32'h0000BEEF, 32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,4'hC,32'h200,  32'hBEEFBEEF};
    tbl[15] = '{1'b1,1'b0,32'h0,    1'b0,2'd3,32'h208,   32'h89ABCDEF, 32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[16] = '{1'b1,1'b0,32'h0,    1'b0,2'd3,32'h208,   32'h89ABCDEF, 32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,4'hF,32'h208,  32'h89ABCDEF};
    tbl[17] = '{1'b1,1'b1,32'h300,  1'b0,2'd3,32'h201,   32'h0,        32'h0,        1'b1, 1'b1,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[18] = '{1'b1,1'b0,32'h0,    1'b1,2'd1,32'h204,   32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[19] = '{1'b1,1'b0,32'h0,    1'b0,2'd2,32'h203,   32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[20] = '{1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0,     32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[21] = '{1'b1,1'b0,32'h0,    1'b0,2'd1,32'h201,   32'h5A,       32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[22] = '{1'b1,1'b0,32'h0,    1'b0,2'd1,32'h201,   32'h5A,       32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,4'h2,32'h200,  32'h5A5A5A5A};
    tbl[23] = '{1'b1,1'b0,32'h0,    1'b1,2'd0,32'h30E,   32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};
    tbl[24] = '{1'b1,1'b0,32'h0,    1'b1,2'd0,32'h30E,   32'h0,        32'h12345678, 1'b1, 1'b0,32'h0,        1'b0,32'h12345678, 1'b0,1'b1,1'b0,4'hF,32'h30C,  32'h0};
    tbl[25] = '{1'b1,1'b0,32'h0,    1'b0,2'd0,32'h0,     32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,    32'h0};

    for (int i = 0; i < 26; i++) apply_vec(tbl[i], i);

    // Starvation: fetch held, data continuously requesting -> D D D D I D.
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    grants  = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h400, 1'b1, 2'd0, 32'h800, 32'h0, 32'h0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus.ram_ren) begin
        own = (bus.ram_addr == 32'h400);
        if (grants < 6) begin
          n_vec++;
          chk("starve_owner", 100 + grants, {31'd0, own}, {31'd0, exp_own[grants]});
        end
        grants++;
      end
    end
    n_vec++;
    chk("starve_grants", 106, grants, 6);

    // Reset during a stalled data access with streak at its limit.
    rs[0] = '{1'b0,1'b0,32'h0,  1'b0,2'd0,32'h0,  32'h0,32'h0,   1'b0, 1'b0,32'h0,1'b0,32'h0,   1'b0,1'b0,1'b0,4'h0,32'h0,  32'h0};
    rs[1] = '{1'b1,1'b1,32'h400,1'b1,2'd0,32'h800,32'h0,32'h11,  1'b1, 1'b1,32'h0,1'b1,32'h0,   1'b0,1'b0,1'b0,4'h0,32'h0,  32'h0};
    rs[2] = '{1'b1,1'b1,32'h400,1'b1,2'd0,32'h800,32'h0,32'h11,  1'b1, 1'b1,32'h0,1'b0,32'h11,  1'b0,1'b1,1'b0,4'hF,32'h800,32'h0};
    rs[3] = rs[1];
    rs[4] = rs[2];
    rs[5] = rs[1];
    rs[6] = rs[2];
    rs[7] = '{1'b1,1'b1,32'h400,1'b1,2'd0,32'h800,32'h0,32'h11,  1'b0, 1'b1,32'h0,1'b1,32'h0,   1'b0,1'b0,1'b0,4'h0,32'h0,  32'h0};
    rs[8] = '{1'b0,1'b1,32'h400,1'b1,2'd0,32'h800,32'h0,32'h11,  1'b0, 1'b1,32'h0,1'b1,32'h0,   1'b0,1'b1,1'b0,4'hF,32'h800,32'h0};
    rs[9] = '{1'b1,1'b1,32'h400,1'b1,2'd0,32'h800,32'h0,32'h11,  1'b0, 1'b1,32'h0,1'b1,32'h0,   1'b0,1'b0,1'b0,4'h0,32'h0,  32'h0};
    for (int i = 0; i < 10; i++) apply_vec(rs[i], 200 + i);
    apply_vec('{1'b1,1'b1,32'h400,1'b1,2'd0,32'h800,32'h0,32'hA5A5,1'b1,
                1'b1,32'h0,1'b0,32'hA5A5,1'b0,1'b1,1'b0,4'hF,32'h800,32'h0}, 210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
